// File: rtl/setpos_pkg.sv
// Shared types and constants for the multi-axis position setter.
package setpos_pkg;

  typedef enum logic [1:0] {
    HOME  = 2'd0,
    IDLE  = 2'd1,
    MOVE  = 2'd2,
    FAULT = 2'd3
  } axis_state_t;

  localparam logic [7:0] BASE_ADDR_DEF   = 8'h04;
  localparam logic [7:0] REHOME_ADDR_DEF = 8'h10;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

endpackage

// File: rtl/setpos_axis.sv
// One motor axis: limit-switch synchronizer, homing/move FSM, position counter.
module setpos_axis
  import setpos_pkg::*;
#(
  parameter int POS_W    = 11,
  parameter int HOME_MAX = 4096
) (
  input  logic             clk50M,
  input  logic             rst_n,
  input  logic             step_tick,
  input  logic             home_n,
  input  logic             target_we,
  input  logic [POS_W-1:0] target_val,
  input  logic             rehome,
  output logic             m_en,
  output logic             dir,
  output logic             homed,
  output logic             fault,
  output logic [POS_W-1:0] pos,
  output logic             in_home
);

  localparam int TMR_W = $clog2(HOME_MAX + 1);

  logic             home_sync_p0;
  logic             home_sync_p1;
  axis_state_t      state;
  logic [POS_W-1:0] target;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nx;
  logic             dir_want;

  assign timer_nx = timer + 1'b1;
  assign dir_want = (pos > target) ? DIR_DEC : DIR_INC;
  assign in_home  = (state == HOME);

  // Two-flop synchronizer for the asynchronous limit switch (free-running, no reset needed)
  always_ff @(posedge clk50M) begin
    home_sync_p0 <= home_n;
    home_sync_p1 <= home_sync_p0;
  end

  // Axis FSM: target capture, re-home override, and per-tick homing/stepping
  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      state  <= HOME;
      pos    <= '0;
      target <= '0;
      timer  <= '0;
      m_en   <= 1'b0;
      dir    <= DIR_DEC;
      homed  <= 1'b0;
      fault  <= 1'b0;
    end else begin
      // The FSM below reads the pre-edge target, so a write on a tick cycle applies next tick
      if (target_we) target <= target_val;

      if (rehome) begin
        state <= HOME;
        m_en  <= 1'b0;
        homed <= 1'b0;
        fault <= 1'b0;
        timer <= '0;
      end else if (step_tick) begin
        case (state)
          HOME: begin
            if (!home_sync_p1) begin
              pos   <= '0;
              m_en  <= 1'b0;
              homed <= 1'b1;
              state <= IDLE;
            end else begin
              dir   <= DIR_DEC;
              timer <= timer_nx;
              if (timer_nx == TMR_W'(HOME_MAX)) begin
                m_en  <= 1'b0;
                fault <= 1'b1;
                state <= FAULT;
              end else begin
                m_en <= 1'b1;
              end
            end
          end
          IDLE, MOVE: begin
            if (pos == target) begin
              m_en  <= 1'b0;
              state <= IDLE;
            end else if (dir_want != dir) begin
              // Direction reversal costs one dead tick with the motor disabled
              dir   <= dir_want;
              m_en  <= 1'b0;
              state <= MOVE;
            end else begin
              m_en  <= 1'b1;
              pos   <= (dir == DIR_DEC) ? pos - 1'b1 : pos + 1'b1;
              state <= MOVE;
            end
          end
          default: begin
            m_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/setpos_multi.sv
// Multi-axis position setter: SPI command decode fanned out to NCH axis instances.
module setpos_multi
  import setpos_pkg::*;
#(
  parameter int         NCH         = 2,
  parameter int         POS_W       = 11,
  parameter int         SHIFT       = 3,
  parameter logic [7:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter logic [7:0] REHOME_ADDR = REHOME_ADDR_DEF,
  parameter int         HOME_MAX    = 4096
) (
  input  logic                   clk50M,
  input  logic                   rst_n,
  input  logic                   step_tick,
  input  logic [15:0]            byte_data_received,
  input  logic                   byte_received,
  input  logic [NCH-1:0]         home_n,
  output logic [NCH-1:0]         m_en,
  output logic [NCH-1:0]         dir,
  output logic [NCH-1:0]         homed,
  output logic [NCH-1:0]         fault,
  output logic [NCH*POS_W-1:0]   pos_flat,
  output logic                   busy
);

  if (POS_W < 8 + SHIFT) begin : g_bad_pos_w
    $error("setpos_multi: POS_W must be >= 8+SHIFT");
  end
  if (NCH > 8) begin : g_bad_nch
    $error("setpos_multi: re-home mask supports at most 8 channels");
  end

  logic [7:0]       addr;
  logic [7:0]       data;
  logic [POS_W-1:0] target_val;
  logic [NCH-1:0]   target_we;
  logic [NCH-1:0]   rehome;
  logic [NCH-1:0]   in_home;

  assign addr       = byte_data_received[15:8];
  assign data       = byte_data_received[7:0];
  assign target_val = POS_W'(data) << SHIFT;
  assign busy       = |(m_en | in_home);

  for (genvar i = 0; i < NCH; i++) begin : g_axis
    localparam logic [7:0] CH_ADDR = 8'(BASE_ADDR + i);

    assign target_we[i] = byte_received && (addr == CH_ADDR);
    assign rehome[i]    = byte_received && (addr == REHOME_ADDR) && data[i];

    setpos_axis #(
      .POS_W    (POS_W),
      .HOME_MAX (HOME_MAX)
    ) u_axis (
      .clk50M     (clk50M),
      .rst_n      (rst_n),
      .step_tick  (step_tick),
      .home_n     (home_n[i]),
      .target_we  (target_we[i]),
      .target_val (target_val),
      .rehome     (rehome[i]),
      .m_en       (m_en[i]),
      .dir        (dir[i]),
      .homed      (homed[i]),
      .fault      (fault[i]),
      .pos        (pos_flat[i*POS_W +: POS_W]),
      .in_home    (in_home[i])
    );
  end

endmodule

// File: tb/tb_setpos_multi.sv
// Bench for setpos_multi: directed test-plan steps plus a random phase, all
// compared every cycle against a behavioural model of the axis rules.
module tb_setpos_multi;

  localparam int NCH      = 2;
  localparam int POS_W    = 11;
  localparam int SHIFT    = 3;
  localparam int HOME_MAX = 4096;
  localparam logic [7:0] BASE   = 8'h04;
  localparam logic [7:0] REHOME = 8'h10;

  logic                 clk50M = 1'b0;
  logic                 rst_n  = 1'b0;
  logic                 step_tick = 1'b0;
  logic [15:0]          byte_data_received = '0;
  logic                 byte_received = 1'b0;
  logic [NCH-1:0]       home_n = '1;
  logic [NCH-1:0]       m_en, dir, homed, fault;
  logic [NCH*POS_W-1:0] pos_flat;
  logic                 busy;

  int checks   = 0;
  int failures = 0;
  int ticks_since_rst = 0;

  // Model: mode 0 = seeking home, 1 = running toward target, 2 = faulted
  int m_mode [NCH];
  int m_pos  [NCH];
  int m_tgt  [NCH];
  int m_tmr  [NCH];
  bit m_on   [NCH];
  bit m_dir  [NCH];
  bit m_hmd  [NCH];
  bit m_flt  [NCH];
  bit m_s0   [NCH];
  bit m_s1   [NCH];

  setpos_multi #(
    .NCH(NCH), .POS_W(POS_W), .SHIFT(SHIFT),
    .BASE_ADDR(BASE), .REHOME_ADDR(REHOME), .HOME_MAX(HOME_MAX)
  ) dut (
    .clk50M(clk50M), .rst_n(rst_n), .step_tick(step_tick),
    .byte_data_received(byte_data_received), .byte_received(byte_received),
    .home_n(home_n), .m_en(m_en), .dir(dir), .homed(homed), .fault(fault),
    .pos_flat(pos_flat), .busy(busy)
  );

  always #10 clk50M = ~clk50M;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dut_pos(input int i);
    return int'(pos_flat[i*POS_W +: POS_W]);
  endfunction

  task automatic model_edge();
    logic [7:0] a, d;
    a = byte_data_received[15:8];
    d = byte_data_received[7:0];
    for (int i = 0; i < NCH; i++) begin
      bit seen;
      bit we, rh;
      seen   = m_s1[i];
      m_s1[i] = m_s0[i];
      m_s0[i] = home_n[i];
      if (!rst_n) begin
        m_mode[i] = 0; m_pos[i] = 0; m_tgt[i] = 0; m_tmr[i] = 0;
        m_on[i] = 0; m_dir[i] = 1; m_hmd[i] = 0; m_flt[i] = 0;
        continue;
      end
      we = byte_received && (a == 8'(BASE + i));
      rh = byte_received && (a == REHOME) && d[i];
      if (rh) begin
        m_mode[i] = 0; m_on[i] = 0; m_hmd[i] = 0; m_flt[i] = 0; m_tmr[i] = 0;
      end else if (step_tick) begin
        if (m_mode[i] == 0) begin
          if (!seen) begin
            m_pos[i] = 0; m_on[i] = 0; m_hmd[i] = 1; m_mode[i] = 1;
          end else begin
            m_dir[i] = 1;
            m_tmr[i] = m_tmr[i] + 1;
            m_on[i]  = (m_tmr[i] < HOME_MAX);
            if (m_tmr[i] >= HOME_MAX) begin
              m_flt[i] = 1; m_mode[i] = 2;
            end
          end
        end else if (m_mode[i] == 1) begin
          int delta;
          delta = m_tgt[i] - m_pos[i];
          if (delta == 0) m_on[i] = 0;
          else if ((delta < 0) != m_dir[i]) begin
            m_dir[i] = (delta < 0);
            m_on[i]  = 0;
          end else begin
            m_on[i]  = 1;
            m_pos[i] = m_pos[i] + ((delta < 0) ? -1 : 1);
          end
        end else begin
          m_on[i] = 0;
        end
      end
      if (we) m_tgt[i] = int'(d) * (1 << SHIFT);
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0]       e_en, e_dir, e_hmd, e_flt;
    logic [NCH*POS_W-1:0] e_pos;
    logic                 e_busy;
    e_busy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      e_en[i]  = m_on[i];
      e_dir[i] = m_dir[i];
      e_hmd[i] = m_hmd[i];
      e_flt[i] = m_flt[i];
      e_pos[i*POS_W +: POS_W] = POS_W'(m_pos[i]);
      e_busy = e_busy | m_on[i] | (m_mode[i] == 0);
    end
    check("model_m_en",  64'(m_en),     64'(e_en));
    check("model_dir",   64'(dir),      64'(e_dir));
    check("model_homed", 64'(homed),    64'(e_hmd));
    check("model_fault", 64'(fault),    64'(e_flt));
    check("model_pos",   64'(pos_flat), 64'(e_pos));
    check("model_busy",  64'(busy),     64'(e_busy));
  endtask

  // One clock: drive at negedge, model and check just after the posedge
  task automatic cyc(input bit tk, input bit bv, input logic [15:0] w);
    step_tick = tk;
    byte_received = bv;
    byte_data_received = w;
    @(posedge clk50M);
    model_edge();
    if (!rst_n) ticks_since_rst = 0;
    else if (tk) ticks_since_rst++;
    #1;
    compare_all();
    @(negedge clk50M);
    step_tick = 1'b0;
    byte_received = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_s0[i] = 1; m_s1[i] = 1;
      m_mode[i] = 0; m_pos[i] = 0; m_tgt[i] = 0; m_tmr[i] = 0;
      m_on[i] = 0; m_dir[i] = 1; m_hmd[i] = 0; m_flt[i] = 0;
    end
    @(negedge clk50M);

    // Reset state
    rst_n = 1'b0; home_n = 2'b11;
    repeat (3) cyc(0, 0, 16'h0000);
    check("rst_m_en",  64'(m_en),     64'd0);
    check("rst_dir",   64'(dir),      64'h3);
    check("rst_homed", 64'(homed),    64'd0);
    check("rst_fault", 64'(fault),    64'd0);
    check("rst_pos",   64'(pos_flat), 64'd0);
    check("rst_busy",  64'(busy),     64'd1);
    rst_n = 1'b1;

    // Channel 0 seeks home for 5 ticks
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 16'h0000);
      check("home_m_en0", 64'(m_en[0]), 64'd1);
      check("home_dir0",  64'(dir[0]),  64'd1);
    end
    home_n[0] = 1'b0;
    repeat (2) cyc(0, 0, 16'h0000);
    cyc(1, 0, 16'h0000);
    check("homed0",      64'(homed[0]),  64'd1);
    check("homed_m_en0", 64'(m_en[0]),   64'd0);
    check("homed_pos0",  64'(dut_pos(0)), 64'd0);

    // Target 16: dead tick then 16 increments
    cyc(0, 1, 16'h0402);
    cyc(1, 0, 16'h0000);
    check("dead_dir0",  64'(dir[0]),  64'd0);
    check("dead_m_en0", 64'(m_en[0]), 64'd0);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 16'h0000);
      check("inc_pos0",  64'(dut_pos(0)), 64'(k));
      check("inc_m_en0", 64'(m_en[0]),    64'd1);
    end
    cyc(1, 0, 16'h0000);
    check("arrive_m_en0", 64'(m_en[0]), 64'd0);

    // Target 8: dead tick then 8 decrements
    cyc(0, 1, 16'h0401);
    cyc(1, 0, 16'h0000);
    check("rev_dir0", 64'(dir[0]),     64'd1);
    check("rev_pos0", 64'(dut_pos(0)), 64'd16);
    repeat (8) cyc(1, 0, 16'h0000);
    check("dec_pos0", 64'(dut_pos(0)), 64'd8);
    cyc(1, 0, 16'h0000);
    check("dec_stop0", 64'(m_en[0]), 64'd0);

    // Channel 1 homing timeout
    for (int k = 0; k < HOME_MAX && !m_flt[1]; k++) cyc(1, 0, 16'h0000);
    check("tmo_ticks",  64'(ticks_since_rst), 64'(HOME_MAX));
    check("tmo_fault1", 64'(fault[1]), 64'd1);
    check("tmo_m_en1",  64'(m_en[1]),  64'd0);
    home_n[1] = 1'b0;
    repeat (2) cyc(1, 0, 16'h0000);
    check("flt_hold1", 64'(fault[1]), 64'd1);
    cyc(0, 1, 16'h1002);
    check("rehome_fault1", 64'(fault[1]), 64'd0);
    check("rehome_busy",   64'(busy),     64'd1);
    cyc(1, 0, 16'h0000);
    check("rehome_homed1", 64'(homed[1]), 64'd1);

    // Target write on a tick cycle uses the old target
    cyc(1, 1, 16'h0505);
    check("oldtgt_m_en1", 64'(m_en[1]),    64'd0);
    check("oldtgt_dir1",  64'(dir[1]),     64'd1);
    check("oldtgt_pos0",  64'(dut_pos(0)), 64'd8);
    cyc(1, 0, 16'h0000);
    check("newtgt_dir1", 64'(dir[1]), 64'd0);
    cyc(0, 1, 16'h2201);
    repeat (3) cyc(1, 0, 16'h0000);

    // Re-home on a tick cycle: no step, pos kept
    cyc(1, 1, 16'h1001);
    check("rh_tick_homed0", 64'(homed[0]),   64'd0);
    check("rh_tick_pos0",   64'(dut_pos(0)), 64'd8);
    cyc(1, 0, 16'h0000);
    check("rh_rehomed_pos0", 64'(dut_pos(0)), 64'd0);

    // Reset while moving
    cyc(0, 1, 16'h0410);
    repeat (6) cyc(1, 0, 16'h0000);
    rst_n = 1'b0;
    cyc(1, 0, 16'h0000);
    check("midrst_m_en", 64'(m_en),     64'd0);
    check("midrst_dir",  64'(dir),      64'h3);
    check("midrst_pos",  64'(pos_flat), 64'd0);
    rst_n = 1'b1;

    // Random phase
    home_n = 2'b00;
    for (int k = 0; k < 4000; k++) begin
      logic [15:0] w;
      logic [7:0]  a;
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 79) == 0) home_n[$urandom_range(0, NCH-1)] ^= 1'b1;
      case ($urandom_range(0, 3))
        0: a = BASE;
        1: a = 8'(BASE + 1);
        2: a = REHOME;
        default: a = 8'($urandom);
      endcase
      w = {a, 8'($urandom)};
      cyc(bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
